// File: rtl/cdc_ctrl_pkg.sv
// Shared definitions for the crossing-source round-robin arbiter.
package cdc_ctrl_pkg;

    // Occupancy of the one-entry output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } cdc_state_e;

    // Tag width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_rr_select.sv
// Combinational round-robin priority search starting at the rr pointer.
module cdc_rr_select #(
    parameter int NumIn = 4,
    parameter int IdxW  = 2
) (
    input  logic [NumIn-1:0] valid,
    input  logic [IdxW-1:0]  rr,
    output logic [NumIn-1:0] grant,
    output logic [IdxW-1:0]  idx,
    output logic             any_valid
);

    // Walk candidates from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            logic [IdxW-1:0] cand;
            cand = IdxW'((int'(rr) + k) % NumIn);
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
                any_valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_src_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry register toward a CDC source half.
module cdc_src_rr_arbiter
    import cdc_ctrl_pkg::*;
#(
    parameter type T     = logic,
    parameter int  NumIn = 4,
    parameter int  IdxW  = idx_width(NumIn)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [NumIn-1:0] req_valid_i,
    output logic [NumIn-1:0] req_ready_o,
    input  T     [NumIn-1:0] req_data_i,
    output logic             cdc_valid_o,
    input  logic             cdc_ready_i,
    output T                 cdc_data_o,
    output logic [IdxW-1:0]  cdc_idx_o,
    output logic             busy_o
);

    cdc_state_e       state_q;
    cdc_state_e       state_d;
    logic [IdxW-1:0]  rr_q;
    logic [IdxW-1:0]  rr_d;
    logic [NumIn-1:0] grant;
    logic [IdxW-1:0]  win_idx;
    logic             any_valid;
    logic             can_accept;
    logic             accept;

    cdc_rr_select #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_select (
        .valid     (req_valid_i),
        .rr        (rr_q),
        .grant     (grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // Handshake side: the register can take an item when empty or draining; rst_ni gates ready during reset.
    always_comb begin
        can_accept  = rst_ni && en_i && ((state_q == EMPTY) || cdc_ready_i);
        accept      = can_accept && any_valid;
        req_ready_o = can_accept ? grant : '0;
        rr_d        = rr_q;
        if (accept) begin
            rr_d = (int'(win_idx) == NumIn - 1) ? '0 : win_idx + IdxW'(1);
        end
    end

    // Next occupancy: a fresh accept always leaves the register full, a drain without refill empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (cdc_ready_i) state_d = accept ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Payload and tag capture; both hold whenever no item is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cdc_data_o <= T'('0);
            cdc_idx_o  <= '0;
        end else if (accept) begin
            cdc_data_o <= req_data_i[win_idx];
            cdc_idx_o  <= win_idx;
        end
    end

    assign cdc_valid_o = (state_q == FULL);
    assign busy_o      = cdc_valid_o;

endmodule

// File: tb/tb_cdc_src_rr_arbiter.sv
// Self-checking bench for cdc_src_rr_arbiter against a behavioural model.
module tb_cdc_src_rr_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0][7:0] req_data;
    logic             cdc_valid;
    logic             cdc_ready;
    logic [7:0]       cdc_data;
    logic [1:0]       cdc_idx;
    logic             busy;

    logic             req_valid1;
    logic             req_ready1;
    logic [0:0][7:0]  req_data1;
    logic             cdc_valid1;
    logic             cdc_ready1;
    logic [7:0]       cdc_data1;
    logic [0:0]       cdc_idx1;
    logic             busy1;

    int checks = 0;
    int passed = 0;

    // Behavioural model state: occupancy, held item, and next priority position.
    bit         m_full;
    logic [7:0] m_data;
    int         m_idx;
    int         m_rr;

    always #5 clk = ~clk;

    cdc_src_rr_arbiter #(.T(logic [7:0]), .NumIn(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .cdc_valid_o(cdc_valid), .cdc_ready_i(cdc_ready), .cdc_data_o(cdc_data),
        .cdc_idx_o(cdc_idx), .busy_o(busy)
    );

    cdc_src_rr_arbiter #(.T(logic [7:0]), .NumIn(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_data_i(req_data1),
        .cdc_valid_o(cdc_valid1), .cdc_ready_i(cdc_ready1), .cdc_data_o(cdc_data1),
        .cdc_idx_o(cdc_idx1), .busy_o(busy1)
    );

    function automatic int model_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_can();
        return rst_n && en && (!m_full || cdc_ready);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = model_winner(req_valid);
        if (model_can() && w >= 0) return N'(1 << w);
        return '0;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_data = 8'h00;
        m_idx  = 0;
        m_rr   = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic model_tick();
        int w;
        bit can;
        @(posedge clk);
        w   = model_winner(req_valid);
        can = model_can();
        if (can && w >= 0) begin
            m_full = 1'b1;
            m_data = req_data[w];
            m_idx  = w;
            m_rr   = (w + 1) % N;
        end else if (m_full && cdc_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req_valid = 4'hF; cdc_ready = 1'b0; rand_data();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (cdc_valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b exp 0", cdc_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b exp 0", busy); else passed++;
        checks++; if (req_ready !== 4'h0) $display("[TB] FAIL reset_ready got %b exp 0000", req_ready); else passed++;
        checks++; if (cdc_data !== 8'h00) $display("[TB] FAIL reset_data got %h exp 00", cdc_data); else passed++;
        checks++; if (cdc_idx !== 2'd0) $display("[TB] FAIL reset_idx got %0d exp 0", cdc_idx); else passed++;
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'h0;
        repeat (2) model_tick();
        checks++; if (cdc_valid !== 1'b0) $display("[TB] FAIL idle_valid got %0b exp 0", cdc_valid); else passed++;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL idle_first_grant got %b exp 0001", req_ready); else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 1'b1; req_valid = 4'hF; cdc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            #1;
            checks++; if (req_ready !== exp_ready() || req_ready !== 4'(1 << (i % 4)))
                $display("[TB] FAIL rr_ready[%0d] got %b exp %b", i, req_ready, 4'(1 << (i % 4))); else passed++;
            model_tick();
            checks++; if (cdc_idx !== 2'(i % 4) || cdc_valid !== 1'b1 || cdc_data !== m_data)
                $display("[TB] FAIL rr_out[%0d] got idx %0d v %0b d %h exp idx %0d v 1 d %h", i, cdc_idx, cdc_valid, cdc_data, i % 4, m_data); else passed++;
        end
    endtask

    task automatic test_sparse_pattern();
        int seq [3] = '{3, 1, 3};
        do_reset();
        en = 1'b1; cdc_ready = 1'b1; req_valid = 4'b0010; rand_data();
        #1;
        model_tick();
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            checks++; if (req_ready !== exp_ready() || req_ready !== 4'(1 << seq[i]))
                $display("[TB] FAIL sparse_ready[%0d] got %b exp %b", i, req_ready, 4'(1 << seq[i])); else passed++;
            model_tick();
            checks++; if (cdc_idx !== 2'(seq[i]) || cdc_data !== m_data)
                $display("[TB] FAIL sparse_out[%0d] got idx %0d d %h exp idx %0d d %h", i, cdc_idx, cdc_data, seq[i], m_data); else passed++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1; cdc_ready = 1'b0; req_valid = 4'b0001; rand_data(); req_data[0] = 8'hA5;
        #1;
        model_tick();
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            #1;
            checks++; if (req_ready !== 4'h0) $display("[TB] FAIL stall_ready[%0d] got %b exp 0000", i, req_ready); else passed++;
            model_tick();
            checks++; if (cdc_data !== 8'hA5 || cdc_valid !== 1'b1 || cdc_idx !== 2'd0)
                $display("[TB] FAIL stall_hold[%0d] got d %h v %0b idx %0d exp d a5 v 1 idx 0", i, cdc_data, cdc_valid, cdc_idx); else passed++;
        end
        cdc_ready = 1'b1; req_valid = 4'h0;
        #1;
        model_tick();
        checks++; if (cdc_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL stall_drain got v %0b busy %0b exp 0 0", cdc_valid, busy); else passed++;
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b1; cdc_ready = 1'b0; req_valid = 4'b0100; rand_data();
        #1;
        model_tick();
        en = 1'b0; cdc_ready = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            #1;
            checks++; if (req_ready !== 4'h0) $display("[TB] FAIL en_low_ready[%0d] got %b exp 0000", i, req_ready); else passed++;
            model_tick();
            checks++; if (cdc_valid !== 1'b0) $display("[TB] FAIL en_low_drain[%0d] got %0b exp 0", i, cdc_valid); else passed++;
        end
        en = 1'b1;
        #1;
        checks++; if (req_ready !== exp_ready() || req_ready !== 4'b1000)
            $display("[TB] FAIL en_resume got %b exp 1000", req_ready); else passed++;
        model_tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; cdc_ready = 1'b0; req_valid = 4'b0100; rand_data();
        #1;
        model_tick();
        checks++; if (cdc_valid !== 1'b1) $display("[TB] FAIL midrst_full got %0b exp 1", cdc_valid); else passed++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (cdc_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0)
            $display("[TB] FAIL midrst_async got v %0b busy %0b rdy %b exp 0 0 0000", cdc_valid, busy, req_ready); else passed++;
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'hF; cdc_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL midrst_grant got %b exp 0001", req_ready); else passed++;
        model_tick();
        checks++; if (cdc_idx !== 2'd0 || cdc_valid !== 1'b1) $display("[TB] FAIL midrst_idx got %0d v %0b exp 0 1", cdc_idx, cdc_valid); else passed++;
    endtask

    task automatic test_random();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            req_valid = 4'($urandom_range(0, 15));
            cdc_ready = ($urandom_range(0, 2) != 0);
            rand_data();
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                errs++;
                if (errs < 10) $display("[TB] FAIL rand_ready[%0d] got %b exp %b", i, req_ready, exp_ready());
            end else passed++;
            model_tick();
            checks++;
            if (cdc_valid !== m_full || busy !== m_full || cdc_data !== m_data || cdc_idx !== 2'(m_idx)) begin
                errs++;
                if (errs < 10) $display("[TB] FAIL rand_out[%0d] got v %0b b %0b d %h idx %0d exp v %0b d %h idx %0d",
                                        i, cdc_valid, busy, cdc_data, cdc_idx, m_full, m_data, m_idx);
            end else passed++;
        end
    endtask

    task automatic test_single();
        logic [7:0] val;
        en = 1'b1; cdc_ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            val = 8'($urandom_range(0, 255));
            req_valid1 = 1'b1; req_data1[0] = val;
            #1;
            checks++; if (req_ready1 !== 1'b1) $display("[TB] FAIL single_ready[%0d] got %0b exp 1", i, req_ready1); else passed++;
            @(posedge clk); #1;
            checks++; if (cdc_data1 !== val || cdc_idx1 !== 1'b0 || cdc_valid1 !== 1'b1)
                $display("[TB] FAIL single_out[%0d] got d %h idx %0d v %0b exp d %h idx 0 v 1", i, cdc_data1, cdc_idx1, cdc_valid1, val); else passed++;
        end
        req_valid1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (cdc_valid1 !== 1'b0) $display("[TB] FAIL single_drain got %0b exp 0", cdc_valid1); else passed++;
    endtask

    initial begin
        req_valid1 = 1'b0; req_data1 = '0; cdc_ready1 = 1'b0;
        test_reset();
        test_round_robin();
        test_sparse_pattern();
        test_stall();
        test_enable();
        test_reset_mid();
        test_random();
        test_single();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
